// File: rtl/rw_burst_txn_fsm.sv
// Read/write burst sequencer: one OUT address transaction followed by up to BURST_MAX
// data transactions (IN for reads, OUT for writes), with bounded per-transaction retry.
module rw_burst_txn_fsm #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 16,
  parameter int MAX_RETRY = 3,
  parameter int BURST_MAX = 8,
  parameter int BURST_W   = $clog2(BURST_MAX + 1),
  parameter int RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               read,
  input  logic               write,
  input  logic [ADDR_W-1:0]  mempage,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [DATA_W-1:0]  data_from_OS,
  input  logic [DATA_W-1:0]  data_from_device,
  input  logic               success,
  input  logic               failure,
  output logic               out_trans,
  output logic               in_trans,
  output logic [DATA_W-1:0]  data_to_device,
  output logic [DATA_W-1:0]  data_to_OS,
  output logic               os_valid,
  output logic               os_next,
  output logic [BURST_W-1:0] word_idx,
  output logic               busy,
  output logic               done,
  output logic               ok,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [2:0]         state_dbg
);

  // Handshake: a transaction is open while out_trans/in_trans is high; the device closes it
  // with a one-cycle success or failure pulse (both together = failure). os_valid marks a
  // fresh data_to_OS word; os_next asks the OS to present the word for the new word_idx.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_GAP  = 3'd2,
    S_DIN  = 3'd3,
    S_DOUT = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [BURST_W-1:0] BMAX = BURST_W'(BURST_MAX);
  localparam logic [RETRY_W-1:0] RMAX = RETRY_W'(MAX_RETRY);

  state_t              state;
  state_t              ret_phase;
  logic                is_read;
  logic [ADDR_W-1:0]   addr_q;
  logic [BURST_W-1:0]  len_q;
  logic [BURST_W-1:0]  len_eff;
  logic [BURST_W-1:0]  idx_inc;
  logic                last_word;
  logic                in_phase;

  always_comb begin
    len_eff = burst_len;
    if (burst_len == '0)
      len_eff = BURST_W'(1);
    else if (burst_len > BMAX)
      len_eff = BMAX;
  end

  assign idx_inc   = word_idx + BURST_W'(1);
  assign last_word = (idx_inc == len_q);
  assign in_phase  = (state == S_ADDR) || (state == S_DIN) || (state == S_DOUT);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state          <= S_IDLE;
      ret_phase      <= S_IDLE;
      is_read        <= 1'b0;
      addr_q         <= '0;
      len_q          <= '0;
      out_trans      <= 1'b0;
      in_trans       <= 1'b0;
      data_to_device <= '0;
      data_to_OS     <= '0;
      os_valid       <= 1'b0;
      os_next        <= 1'b0;
      word_idx       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      ok             <= 1'b0;
      retry_cnt      <= '0;
    end else begin
      os_valid <= 1'b0;
      os_next  <= 1'b0;
      done     <= 1'b0;
      if (in_phase && failure) begin
        // Failure wins over a simultaneous success; the phase is re-entered after a gap.
        out_trans <= 1'b0;
        in_trans  <= 1'b0;
        if (retry_cnt == RMAX) begin
          state <= S_DONE;
          done  <= 1'b1;
          ok    <= 1'b0;
        end else begin
          retry_cnt <= retry_cnt + RETRY_W'(1);
          ret_phase <= state;
          state     <= S_GAP;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (read || write) begin
              is_read        <= read;
              addr_q         <= mempage;
              len_q          <= len_eff;
              word_idx       <= '0;
              retry_cnt      <= '0;
              ok             <= 1'b0;
              busy           <= 1'b1;
              out_trans      <= 1'b1;
              data_to_device <= DATA_W'(mempage);
              state          <= S_ADDR;
            end
          end
          S_ADDR: begin
            if (success) begin
              out_trans <= 1'b0;
              retry_cnt <= '0;
              ret_phase <= is_read ? S_DIN : S_DOUT;
              state     <= S_GAP;
            end
          end
          S_GAP: begin
            state <= ret_phase;
            case (ret_phase)
              S_ADDR: begin
                out_trans      <= 1'b1;
                data_to_device <= DATA_W'(addr_q);
              end
              S_DIN:  in_trans <= 1'b1;
              default: begin
                out_trans      <= 1'b1;
                data_to_device <= data_from_OS;
              end
            endcase
          end
          S_DIN: begin
            if (success) begin
              in_trans   <= 1'b0;
              data_to_OS <= data_from_device;
              os_valid   <= 1'b1;
              word_idx   <= idx_inc;
              retry_cnt  <= '0;
              if (last_word) begin
                state <= S_DONE;
                done  <= 1'b1;
                ok    <= 1'b1;
              end else begin
                ret_phase <= S_DIN;
                state     <= S_GAP;
              end
            end
          end
          S_DOUT: begin
            data_to_device <= data_from_OS;
            if (success) begin
              out_trans <= 1'b0;
              os_next   <= 1'b1;
              word_idx  <= idx_inc;
              retry_cnt <= '0;
              if (last_word) begin
                state <= S_DONE;
                done  <= 1'b1;
                ok    <= 1'b1;
              end else begin
                ret_phase <= S_DOUT;
                state     <= S_GAP;
              end
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            ok    <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rw_burst_txn_fsm.sv
// Directed scoreboard bench for rw_burst_txn_fsm: a device responder answers each
// transaction from a response queue, a monitor checks transactions, read data and done.
module tb_rw_burst_txn_fsm;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [15:0] mempage = '0;
  logic [3:0]  burst_len = '0;
  logic [63:0] data_from_OS = '0;
  logic [63:0] data_from_device = '0;
  logic        success = 1'b0;
  logic        failure = 1'b0;
  logic        out_trans, in_trans, os_valid, os_next, busy, done, ok;
  logic [63:0] data_to_device, data_to_OS;
  logic [3:0]  word_idx;
  logic [1:0]  retry_cnt;
  logic [2:0]  state_dbg;

  rw_burst_txn_fsm dut (
    .clk(clk), .rst_b(rst_b), .read(read), .write(write), .mempage(mempage),
    .burst_len(burst_len), .data_from_OS(data_from_OS), .data_from_device(data_from_device),
    .success(success), .failure(failure), .out_trans(out_trans), .in_trans(in_trans),
    .data_to_device(data_to_device), .data_to_OS(data_to_OS), .os_valid(os_valid),
    .os_next(os_next), .word_idx(word_idx), .busy(busy), .done(done), .ok(ok),
    .retry_cnt(retry_cnt), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int os_next_cnt = 0;

  logic [70:0] exp_txn_q[$];
  logic [63:0] exp_data_q[$];
  logic [6:0]  exp_done_q[$];
  logic [1:0]  resp_q[$];   // 0 = success, 1 = failure, 2 = both strobes

  logic [63:0] rd_words[16];
  logic [63:0] wr_words[16];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [70:0] mk_txn(input logic is_in, input logic [3:0] idx,
                                         input logic [1:0] r, input logic [63:0] d);
    return {is_in, idx, r, is_in ? 64'h0 : d};
  endfunction

  task automatic exp_txn(input logic is_in, input logic [3:0] idx, input logic [1:0] r,
                         input logic [63:0] d);
    exp_txn_q.push_back(mk_txn(is_in, idx, r, d));
  endtask

  // Device model and OS word source.
  always @(negedge clk) begin
    logic [1:0] r;
    success = 1'b0;
    failure = 1'b0;
    data_from_OS     = wr_words[word_idx];
    data_from_device = rd_words[word_idx];
    if (rst_b && (out_trans || in_trans) && resp_q.size() > 0) begin
      r = resp_q.pop_front();
      success = (r != 2'd1);
      failure = (r != 2'd0);
    end
  end

  // Monitor.
  logic prev_out = 1'b0, prev_in = 1'b0;
  always @(negedge clk) begin
    if (rst_b) begin
      if ((out_trans && !prev_out) || (in_trans && !prev_in)) begin
        if (exp_txn_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_txn in=%0b idx=%0d", in_trans, word_idx);
        end else
          check("txn", mk_txn(in_trans, word_idx, retry_cnt, data_to_device), exp_txn_q.pop_front());
      end
      if (os_valid) begin
        if (exp_data_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_os_valid data=%0h", data_to_OS);
        end else
          check("data_to_OS", data_to_OS, exp_data_q.pop_front());
      end
      if (os_valid && os_next) begin
        failures++;
        $display("FAIL os_valid_and_os_next act=1 exp=0");
      end
      if (os_next) os_next_cnt++;
      if (done) begin
        done_cnt++;
        if (exp_done_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done ok=%0b", ok);
        end else
          check("done_ok_idx_retry", {ok, word_idx, retry_cnt}, exp_done_q.pop_front());
      end
    end
    prev_out = out_trans;
    prev_in  = in_trans;
  end

  task automatic issue(input bit rd, input logic [15:0] addr, input logic [3:0] len);
    @(negedge clk);
    read = rd; write = !rd; mempage = addr; burst_len = len;
    @(negedge clk);
    read = 1'b0; write = 1'b0;
  endtask

  task automatic wait_done();
    int start = done_cnt;
    int i = 0;
    while (done_cnt == start && i < 300) begin
      @(negedge clk);
      i++;
    end
    if (done_cnt == start) begin
      failures++;
      $display("FAIL done_timeout act=0 exp=1");
    end
    @(negedge clk);
  endtask

  task automatic end_checks(input string tname, input int exp_next);
    check({tname, "_txn_q_empty"}, exp_txn_q.size(), 0);
    check({tname, "_data_q_empty"}, exp_data_q.size(), 0);
    check({tname, "_done_q_empty"}, exp_done_q.size(), 0);
    check({tname, "_resp_q_empty"}, resp_q.size(), 0);
    check({tname, "_os_next_cnt"}, os_next_cnt, exp_next);
    exp_txn_q.delete(); exp_data_q.delete(); exp_done_q.delete(); resp_q.delete();
    os_next_cnt = 0;
  endtask

  function automatic logic [127:0] all_outs();
    return {out_trans, in_trans, os_valid, os_next, busy, done, ok, word_idx, retry_cnt,
            data_to_device[31:0], data_to_OS[31:0], |data_to_device[63:32], |data_to_OS[63:32]};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int saved;
    for (int i = 0; i < 16; i++) begin
      rd_words[i] = {32'hD00D_0000, 32'(i) * 32'h0101_0101};
      wr_words[i] = {32'hA5A5_0000, 32'(i) * 32'h1111_1111};
    end
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    rst_b = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", all_outs(), 0);

    // T1: single-word read.
    resp_q = '{2'd0, 2'd0};
    exp_txn(0, 0, 0, 64'hA5); exp_txn(1, 0, 0, 0);
    exp_data_q.push_back(rd_words[0]);
    exp_done_q.push_back({1'b1, 4'd1, 2'd0});
    issue(1, 16'h00A5, 4'd1);
    wait_done();
    end_checks("t1", 0);

    // T2: four-word write; a write strobe while busy must be ignored.
    resp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    exp_txn(0, 0, 0, 64'h1234);
    for (int i = 0; i < 4; i++) exp_txn(0, 4'(i), 0, wr_words[i]);
    exp_done_q.push_back({1'b1, 4'd4, 2'd0});
    issue(0, 16'h1234, 4'd4);
    write = 1'b1; @(negedge clk); write = 1'b0;
    wait_done();
    end_checks("t2", 4);

    // T3: two-word read, second word fails twice.
    resp_q = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
    exp_txn(0, 0, 0, 64'h2); exp_txn(1, 0, 0, 0);
    exp_txn(1, 1, 0, 0); exp_txn(1, 1, 1, 0); exp_txn(1, 1, 2, 0);
    exp_data_q.push_back(rd_words[0]); exp_data_q.push_back(rd_words[1]);
    exp_done_q.push_back({1'b1, 4'd2, 2'd0});
    issue(1, 16'h0002, 4'd2);
    wait_done();
    end_checks("t3", 0);

    // T4: address phase exhausts all retries.
    resp_q = '{2'd1, 2'd1, 2'd1, 2'd1};
    for (int r = 0; r < 4; r++) exp_txn(0, 0, 2'(r), 64'hF0);
    exp_done_q.push_back({1'b0, 4'd0, 2'd3});
    issue(0, 16'h00F0, 4'd3);
    wait_done();
    end_checks("t4", 0);

    // T5a: success and failure together count as failure.
    resp_q = '{2'd0, 2'd2, 2'd0};
    exp_txn(0, 0, 0, 64'h55); exp_txn(0, 0, 0, wr_words[0]); exp_txn(0, 0, 1, wr_words[0]);
    exp_done_q.push_back({1'b1, 4'd1, 2'd0});
    issue(0, 16'h0055, 4'd1);
    wait_done();
    end_checks("t5a", 1);

    // T5b: burst_len 0 gives one word.
    resp_q = '{2'd0, 2'd0};
    exp_txn(0, 0, 0, 64'h3); exp_txn(1, 0, 0, 0);
    exp_data_q.push_back(rd_words[0]);
    exp_done_q.push_back({1'b1, 4'd1, 2'd0});
    issue(1, 16'h0003, 4'd0);
    wait_done();
    end_checks("t5b", 0);

    // T5c: burst_len 12 is clamped to 8 words.
    for (int i = 0; i < 9; i++) resp_q.push_back(2'd0);
    exp_txn(0, 0, 0, 64'h7);
    for (int i = 0; i < 8; i++) begin
      exp_txn(1, 4'(i), 0, 0);
      exp_data_q.push_back(rd_words[i]);
    end
    exp_done_q.push_back({1'b1, 4'd8, 2'd0});
    issue(1, 16'h0007, 4'd12);
    wait_done();
    end_checks("t5c", 0);

    // T6: reset in the middle of a write burst.
    resp_q = '{2'd0, 2'd0, 2'd0};
    exp_txn(0, 0, 0, 64'h0AB0); exp_txn(0, 0, 0, wr_words[0]); exp_txn(0, 1, 0, wr_words[1]);
    saved = done_cnt;
    issue(0, 16'h0AB0, 4'd4);
    for (int i = 0; i < 100 && word_idx != 4'd2; i++) @(negedge clk);
    check("t6_reached_idx2", word_idx, 4'd2);
    #2 rst_b = 1'b0;
    #1 check("t6_async_reset_outputs", all_outs(), 0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    check("t6_no_done", done_cnt, saved);
    end_checks("t6", 2);

    resp_q = '{2'd0, 2'd0};
    exp_txn(0, 0, 0, 64'h99); exp_txn(1, 0, 0, 0);
    exp_data_q.push_back(rd_words[0]);
    exp_done_q.push_back({1'b1, 4'd1, 2'd0});
    issue(1, 16'h0099, 4'd1);
    wait_done();
    end_checks("t6b", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
